// File: rtl/sht40_convert.sv
`default_nettype none
// ============================================================================
//  Module   : sht40_convert
//  Purpose  : Converts raw 16-bit SHT40 temperature / humidity ticks into
//             signed centi-degrees Celsius and clamped unsigned centi-%RH,
//             using one shared 16-iteration shift-add multiplier.
//  Ports    : clk, rst_n (sync, active-low)
//             Temperature_Output / Humidity_Output : raw ticks in
//             Temp_Ready_Out / RH_Ready_Out        : level flags, rising edge = new word
//             Temp_Centi / RH_Centi                : converted results (held)
//             Temp_Valid / RH_Valid                : one-cycle update pulses
//             Busy                                 : conversion in progress
//             Overrun                              : pending raw word overwritten
//  Revision : 1.0  initial release
// ============================================================================
module sht40_convert #(
  parameter int T_SCALE   = 17500,
  parameter int T_OFFSET  = 4500,
  parameter int RH_SCALE  = 12500,
  parameter int RH_OFFSET = 600,
  parameter int RH_MAX    = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Temperature_Output,
  input  logic [15:0] Humidity_Output,
  input  logic        Temp_Ready_Out,
  input  logic        RH_Ready_Out,
  output logic [15:0] Temp_Centi,
  output logic [15:0] RH_Centi,
  output logic        Temp_Valid,
  output logic        RH_Valid,
  output logic        Busy,
  output logic        Overrun
);

  localparam logic [15:0] C_T_SCALE   = 16'(T_SCALE);
  localparam logic [15:0] C_T_OFFSET  = 16'(T_OFFSET);
  localparam logic [15:0] C_RH_SCALE  = 16'(RH_SCALE);
  localparam logic [15:0] C_RH_OFFSET = 16'(RH_OFFSET);
  localparam logic [15:0] C_RH_MAX    = 16'(RH_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_ADJ  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_t_rdy_q;
  logic        r_rh_rdy_q;
  logic        r_t_pend;
  logic        r_rh_pend;
  logic [15:0] r_t_raw;
  logic [15:0] r_rh_raw;

  logic        r_chan_rh;
  logic [15:0] r_mplier;
  logic [15:0] r_mcand;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;

  logic [15:0] r_temp;
  logic [15:0] r_rh;
  logic        r_t_valid;
  logic        r_rh_valid;
  logic        r_overrun;

  logic        w_t_rise;
  logic        w_rh_rise;
  logic        w_take_t;
  logic        w_take_rh;
  logic [31:0] w_addend;
  logic [15:0] w_hi;
  logic [15:0] w_t_res;
  logic [15:0] w_rh_diff;
  logic [15:0] w_rh_res;

  // Edge registers reset to 0, so a ready held high through reset release
  // is seen as a rising edge on the first active cycle.
  assign w_t_rise  = Temp_Ready_Out & ~r_t_rdy_q;
  assign w_rh_rise = RH_Ready_Out   & ~r_rh_rdy_q;

  // Temperature wins when both channels are pending.
  assign w_take_t  = (r_state == S_IDLE) & r_t_pend;
  assign w_take_rh = (r_state == S_IDLE) & ~r_t_pend & r_rh_pend;

  assign w_addend  = {16'd0, r_mcand} << r_cnt;
  assign w_hi      = r_acc[31:16];

  // Temperature result always fits in 16-bit two's complement, so modular
  // subtraction yields the correct signed value.
  assign w_t_res   = w_hi - C_T_OFFSET;
  assign w_rh_diff = w_hi - C_RH_OFFSET;

  always_comb begin
    w_rh_res = w_rh_diff;
    if (w_hi < C_RH_OFFSET) begin
      w_rh_res = 16'd0;
    end else if (w_rh_diff > C_RH_MAX) begin
      w_rh_res = C_RH_MAX;
    end
  end

  // -------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_t_pend | r_rh_pend) w_state_nxt = S_MULT;
      S_MULT:  if (r_cnt == 4'd15)       w_state_nxt = S_ADJ;
      S_ADJ:                             w_state_nxt = S_IDLE;
      default:                           w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------ capture / pending
  // A new edge arriving on the same cycle its channel is consumed keeps the
  // flag set: the old word is already being loaded, so nothing is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t_rdy_q  <= 1'b0;
      r_rh_rdy_q <= 1'b0;
      r_t_pend   <= 1'b0;
      r_rh_pend  <= 1'b0;
      r_t_raw    <= 16'd0;
      r_rh_raw   <= 16'd0;
      r_overrun  <= 1'b0;
    end else begin
      r_t_rdy_q  <= Temp_Ready_Out;
      r_rh_rdy_q <= RH_Ready_Out;
      if (w_t_rise) begin
        r_t_pend <= 1'b1;
        r_t_raw  <= Temperature_Output;
      end else if (w_take_t) begin
        r_t_pend <= 1'b0;
      end
      if (w_rh_rise) begin
        r_rh_pend <= 1'b1;
        r_rh_raw  <= Humidity_Output;
      end else if (w_take_rh) begin
        r_rh_pend <= 1'b0;
      end
      r_overrun <= (w_t_rise  & r_t_pend  & ~w_take_t) |
                   (w_rh_rise & r_rh_pend & ~w_take_rh);
    end
  end

  // ---------------------------------------------- multiply / adjust
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chan_rh  <= 1'b0;
      r_mplier   <= 16'd0;
      r_mcand    <= 16'd0;
      r_acc      <= 32'd0;
      r_cnt      <= 4'd0;
      r_temp     <= 16'd0;
      r_rh       <= 16'd0;
      r_t_valid  <= 1'b0;
      r_rh_valid <= 1'b0;
    end else begin
      r_t_valid  <= 1'b0;
      r_rh_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take_t | w_take_rh) begin
            r_chan_rh <= w_take_rh;
            r_mplier  <= w_take_t ? r_t_raw   : r_rh_raw;
            r_mcand   <= w_take_t ? C_T_SCALE : C_RH_SCALE;
            r_acc     <= 32'd0;
            r_cnt     <= 4'd0;
          end
        end
        S_MULT: begin
          if (r_mplier[r_cnt]) begin
            r_acc <= r_acc + w_addend;
          end
          r_cnt <= r_cnt + 4'd1;
        end
        S_ADJ: begin
          if (r_chan_rh) begin
            r_rh       <= w_rh_res;
            r_rh_valid <= 1'b1;
          end else begin
            r_temp    <= w_t_res;
            r_t_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Temp_Centi = r_temp;
  assign RH_Centi   = r_rh;
  assign Temp_Valid = r_t_valid;
  assign RH_Valid   = r_rh_valid;
  assign Overrun    = r_overrun;
  // Busy stays high through the result-publishing cycle so that
  // back-to-back conversions present one continuous busy window.
  assign Busy       = (r_state != S_IDLE) | r_t_valid | r_rh_valid;

endmodule
`default_nettype wire

// File: tb/tb_sht40_convert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sht40_convert
//  Purpose  : Self-checking bench for sht40_convert: a transaction-level
//             reference model checked every cycle, plus directed vectors
//             with hand-computed results and latencies.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sht40_convert;

  localparam int T_SCALE   = 17500;
  localparam int T_OFFSET  = 4500;
  localparam int RH_SCALE  = 12500;
  localparam int RH_OFFSET = 600;
  localparam int RH_MAX    = 10000;
  localparam int LAT       = 18;

  logic        clk;
  logic        rst_n;
  logic [15:0] Temperature_Output;
  logic [15:0] Humidity_Output;
  logic        Temp_Ready_Out;
  logic        RH_Ready_Out;
  logic [15:0] Temp_Centi;
  logic [15:0] RH_Centi;
  logic        Temp_Valid;
  logic        RH_Valid;
  logic        Busy;
  logic        Overrun;

  sht40_convert #(
    .T_SCALE  (T_SCALE),
    .T_OFFSET (T_OFFSET),
    .RH_SCALE (RH_SCALE),
    .RH_OFFSET(RH_OFFSET),
    .RH_MAX   (RH_MAX)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .Temperature_Output(Temperature_Output),
    .Humidity_Output   (Humidity_Output),
    .Temp_Ready_Out    (Temp_Ready_Out),
    .RH_Ready_Out      (RH_Ready_Out),
    .Temp_Centi        (Temp_Centi),
    .RH_Centi          (RH_Centi),
    .Temp_Valid        (Temp_Valid),
    .RH_Valid          (RH_Valid),
    .Busy              (Busy),
    .Overrun           (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int ov_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ------------------------------------------------ reference model
  function automatic int t_conv(input logic [15:0] raw);
    longint p;
    p = longint'(T_SCALE) * longint'(raw);
    return int'(p / 65536) - T_OFFSET;
  endfunction

  function automatic int rh_conv(input logic [15:0] raw);
    longint p;
    int     v;
    p = longint'(RH_SCALE) * longint'(raw);
    v = int'(p / 65536) - RH_OFFSET;
    if (v < 0)      v = 0;
    if (v > RH_MAX) v = RH_MAX;
    return v;
  endfunction

  // Model: a queue of at most one pending word per channel, one conversion
  // in flight that completes LAT-1 edges after it starts.
  bit          m_prev_t, m_prev_r, m_tp, m_rp, m_act, m_ch, m_tv, m_rv, m_ov;
  logic [15:0] m_tw, m_rw, m_word;
  int          m_rem, m_tc, m_rc;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev_t = 0; m_prev_r = 0; m_tp = 0; m_rp = 0; m_act = 0; m_ch = 0;
      m_tv = 0; m_rv = 0; m_ov = 0; m_rem = 0; m_tc = 0; m_rc = 0;
    end else begin
      m_tv = 0; m_rv = 0; m_ov = 0;
      if (m_act) begin
        m_rem--;
        if (m_rem == 0) begin
          m_act = 0;
          if (m_ch) begin m_rc = rh_conv(m_word); m_rv = 1; end
          else      begin m_tc = t_conv(m_word);  m_tv = 1; end
        end
      end else if (m_tp) begin
        m_act = 1; m_rem = LAT - 1; m_ch = 0; m_word = m_tw; m_tp = 0;
      end else if (m_rp) begin
        m_act = 1; m_rem = LAT - 1; m_ch = 1; m_word = m_rw; m_rp = 0;
      end
      if (Temp_Ready_Out && !m_prev_t) begin
        if (m_tp) m_ov = 1;
        m_tp = 1; m_tw = Temperature_Output;
      end
      if (RH_Ready_Out && !m_prev_r) begin
        if (m_rp) m_ov = 1;
        m_rp = 1; m_rw = Humidity_Output;
      end
      m_prev_t = Temp_Ready_Out;
      m_prev_r = RH_Ready_Out;
    end
    #1;
    check("cyc_temp_centi", {16'd0, Temp_Centi}, {16'd0, 16'(m_tc)});
    check("cyc_rh_centi",   {16'd0, RH_Centi},   {16'd0, 16'(m_rc)});
    check("cyc_temp_valid", {31'd0, Temp_Valid}, {31'd0, m_tv});
    check("cyc_rh_valid",   {31'd0, RH_Valid},   {31'd0, m_rv});
    check("cyc_busy",       {31'd0, Busy},       {31'd0, (m_act | m_tv | m_rv)});
    check("cyc_overrun",    {31'd0, Overrun},    {31'd0, m_ov});
    if (Overrun === 1'b1) ov_cnt++;
  end

  // ------------------------------------------------ directed helpers
  // Called between edges; counts edges after E0 until the chosen Valid.
  task automatic wait_valid(input bit rh, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #2;
      if ((rh ? RH_Valid : Temp_Valid) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic conv(input bit rh, input logic [15:0] raw, input logic [15:0] exp, input string nm);
    int lat;
    @(negedge clk);
    if (rh) begin Humidity_Output = raw;    RH_Ready_Out   = 1'b1; end
    else    begin Temperature_Output = raw; Temp_Ready_Out = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    Temp_Ready_Out = 1'b0;
    RH_Ready_Out   = 1'b0;
    wait_valid(rh, lat);
    check({nm, "_latency"}, lat, LAT);
    check({nm, "_value"}, {16'd0, rh ? RH_Centi : Temp_Centi}, {16'd0, exp});
    repeat (2) @(negedge clk);
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    int lat;
    int ov_base;
    int vcount;
    rst_n = 1'b0;
    Temperature_Output = 16'd0;
    Humidity_Output    = 16'd0;
    Temp_Ready_Out     = 1'b0;
    RH_Ready_Out       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_temp", {16'd0, Temp_Centi}, 32'd0);
    check("reset_rh",   {16'd0, RH_Centi},   32'd0);
    check("reset_busy", {31'd0, Busy},       32'd0);

    conv(1'b0, 16'h8000, 16'd4250,  "t_8000");
    check("t_8000_rh_untouched", {16'd0, RH_Centi}, 32'd0);
    conv(1'b0, 16'h0000, 16'hEE6C,  "t_0000");
    conv(1'b0, 16'hFFFF, 16'd12999, "t_ffff");
    conv(1'b0, 16'h6666, 16'd2499,  "t_6666");

    conv(1'b1, 16'hFFFF, 16'd10000, "rh_ffff");
    conv(1'b1, 16'h0C49, 16'd0,     "rh_0c49");
    conv(1'b1, 16'h8000, 16'd5650,  "rh_8000");
    conv(1'b1, 16'h0C4A, 16'd0,     "rh_0c4a");

    // Both channels rise together: T at E18, RH at E36, Busy unbroken.
    @(negedge clk);
    Temperature_Output = 16'h8000; Temp_Ready_Out = 1'b1;
    Humidity_Output    = 16'h8000; RH_Ready_Out   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Temp_Ready_Out = 1'b0; RH_Ready_Out = 1'b0;
    for (int k = 1; k <= 2 * LAT; k++) begin
      @(posedge clk); #2;
      check("both_busy", {31'd0, Busy}, 32'd1);
      if (k == LAT) begin
        check("both_t_valid", {31'd0, Temp_Valid}, 32'd1);
        check("both_t_value", {16'd0, Temp_Centi}, 32'd4250);
      end
      if (k == 2 * LAT) begin
        check("both_rh_valid", {31'd0, RH_Valid}, 32'd1);
        check("both_rh_value", {16'd0, RH_Centi}, 32'd5650);
      end
    end
    repeat (2) @(negedge clk);

    // Two RH words during a temperature conversion: one overrun, last word wins.
    ov_base = ov_cnt;
    @(negedge clk);
    Temperature_Output = 16'h8000; Temp_Ready_Out = 1'b1;
    @(negedge clk);
    Temp_Ready_Out = 1'b0;
    repeat (2) @(negedge clk);
    Humidity_Output = 16'h0000; RH_Ready_Out = 1'b1;
    @(negedge clk);
    RH_Ready_Out = 1'b0;
    @(negedge clk);
    Humidity_Output = 16'hFFFF; RH_Ready_Out = 1'b1;
    @(negedge clk);
    RH_Ready_Out = 1'b0;
    wait_valid(1'b0, lat);
    check("ovr_t_seen", {31'd0, (lat != 0)}, 32'd1);
    wait_valid(1'b1, lat);
    check("ovr_rh_seen",  {31'd0, (lat != 0)}, 32'd1);
    check("ovr_rh_value", {16'd0, RH_Centi}, 32'd10000);
    repeat (2) @(negedge clk);
    check("ovr_pulses", ov_cnt - ov_base, 32'd1);

    // Reset sampled at E10 of a conversion aborts it silently.
    vcount = 0;
    @(negedge clk);
    Temperature_Output = 16'hFFFF; Temp_Ready_Out = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Temp_Ready_Out = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #2;
      if (Temp_Valid === 1'b1 || RH_Valid === 1'b1) vcount++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("abort_temp", {16'd0, Temp_Centi}, 32'd0);
    check("abort_rh",   {16'd0, RH_Centi},   32'd0);
    check("abort_busy", {31'd0, Busy},       32'd0);
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #2;
      if (Temp_Valid === 1'b1 || RH_Valid === 1'b1) vcount++;
    end
    check("abort_no_valid", vcount, 32'd0);
    @(negedge clk);
    conv(1'b0, 16'h6666, 16'd2499, "after_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
